// File: rtl/bcd_modcnt_if.sv
// Command/status bundle for bcd_modcnt.
// master: the tick generator / manual-set controller driving commands.
// slave : the counter itself.
interface bcd_modcnt_if;
  logic       tick;
  logic       down;
  logic       set_L;
  logic       set_H;
  logic       load;
  logic [3:0] load_L;
  logic [3:0] load_H;
  logic [3:0] cnt_L;
  logic [3:0] cnt_H;
  logic       carry;
  logic       borrow;
  logic       load_err;

  modport master (
    output tick, down, set_L, set_H, load, load_L, load_H,
    input  cnt_L, cnt_H, carry, borrow, load_err
  );

  modport slave (
    input  tick, down, set_L, set_H, load, load_L, load_H,
    output cnt_L, cnt_H, carry, borrow, load_err
  );
endinterface

// File: rtl/bcd_modcnt.sv
// Two-digit BCD modulo-MOD counter (hour/minute/second digit pairs).
// Commands by priority: clr > load > set_L > set_H > tick.
// Optional macro BCD_CNT_DOWN_EN: enables down-counting on tick and the
// borrow pulse; without it, down is ignored and borrow stays 0.
module bcd_modcnt #(
  parameter int unsigned MOD     = 24,
  parameter int unsigned RST_VAL = 0
) (
  input  logic          clk_1,
  input  logic          clr,
  bcd_modcnt_if.slave   bus
);

  localparam logic [7:0] MOD_V = 8'(MOD);
  localparam logic [7:0] TOP_V = 8'(MOD - 1);
  localparam logic [3:0] RST_H = 4'(RST_VAL / 10);
  localparam logic [3:0] RST_L = 4'(RST_VAL % 10);
`ifdef BCD_CNT_DOWN_EN
  localparam logic [3:0] TOP_H = 4'((MOD - 1) / 10);
  localparam logic [3:0] TOP_L = 4'((MOD - 1) % 10);
`endif

  typedef enum logic [2:0] {
    CMD_IDLE,
    CMD_LOAD,
    CMD_SET_L,
    CMD_SET_H,
    CMD_TICK
  } cmd_e;

  typedef struct packed {
    logic [3:0] h;
    logic [3:0] l;
    logic       wrap;
  } step_t;

  // Binary value of a digit pair; wide enough for unchecked load digits.
  function automatic logic [7:0] bcd_val(input logic [3:0] h, input logic [3:0] l);
    return (8'd10 * {4'd0, h}) + {4'd0, l};
  endfunction

  function automatic step_t step_up(input logic [3:0] h, input logic [3:0] l);
    step_t s;
    s.h    = h;
    s.l    = l;
    s.wrap = 1'b0;
    if (bcd_val(h, l) >= TOP_V) begin
      s.h    = '0;
      s.l    = '0;
      s.wrap = 1'b1;
    end else if (l == 4'd9) begin
      s.l = '0;
      s.h = h + 4'd1;
    end else begin
      s.l = l + 4'd1;
    end
    return s;
  endfunction

`ifdef BCD_CNT_DOWN_EN
  function automatic step_t step_down(input logic [3:0] h, input logic [3:0] l);
    step_t s;
    s.h    = h;
    s.l    = l;
    s.wrap = 1'b0;
    if ((h == 4'd0) && (l == 4'd0)) begin
      s.h    = TOP_H;
      s.l    = TOP_L;
      s.wrap = 1'b1;
    end else if (l == 4'd0) begin
      s.l = 4'd9;
      s.h = h - 4'd1;
    end else begin
      s.l = l - 4'd1;
    end
    return s;
  endfunction
`endif

  logic [3:0] cnt_h_q, cnt_l_q;
  logic       carry_q, err_q;
  logic [3:0] nxt_h, nxt_l;
  logic       nxt_carry, nxt_err;
  logic       load_ok;
  logic       dir_down;
  cmd_e       cmd;

`ifdef BCD_CNT_DOWN_EN
  logic borrow_q;
  logic nxt_borrow;
  assign dir_down = bus.down;
`else
  logic unused_down;
  assign unused_down = bus.down;
  assign dir_down    = 1'b0;
`endif

  // Range check of the parallel-load digits.
  always_comb begin
    load_ok = (bus.load_L <= 4'd9) && (bus.load_H <= 4'd9) &&
              (bcd_val(bus.load_H, bus.load_L) < MOD_V);
  end

  // Pick the single highest-priority active command.
  always_comb begin
    cmd = CMD_IDLE;
    if (bus.load)       cmd = CMD_LOAD;
    else if (bus.set_L) cmd = CMD_SET_L;
    else if (bus.set_H) cmd = CMD_SET_H;
    else if (bus.tick)  cmd = CMD_TICK;
  end

  // Next digit pair and pulse flags for the selected command.
  always_comb begin
    step_t st;
    nxt_h     = cnt_h_q;
    nxt_l     = cnt_l_q;
    nxt_carry = 1'b0;
    nxt_err   = 1'b0;
    st        = '0;
`ifdef BCD_CNT_DOWN_EN
    nxt_borrow = 1'b0;
`endif
    unique case (cmd)
      CMD_LOAD: begin
        if (load_ok) begin
          nxt_h = bus.load_H;
          nxt_l = bus.load_L;
        end else begin
          nxt_err = 1'b1;
        end
      end
      CMD_SET_L: begin
        if ((cnt_l_q == 4'd9) || (bcd_val(cnt_h_q, cnt_l_q) >= TOP_V))
          nxt_l = '0;
        else
          nxt_l = cnt_l_q + 4'd1;
      end
      CMD_SET_H: begin
        if (bcd_val(cnt_h_q + 4'd1, cnt_l_q) >= MOD_V)
          nxt_h = '0;
        else
          nxt_h = cnt_h_q + 4'd1;
      end
      CMD_TICK: begin
`ifdef BCD_CNT_DOWN_EN
        if (dir_down) begin
          st         = step_down(cnt_h_q, cnt_l_q);
          nxt_borrow = st.wrap;
        end else begin
          st        = step_up(cnt_h_q, cnt_l_q);
          nxt_carry = st.wrap;
        end
`else
        st        = step_up(cnt_h_q, cnt_l_q);
        nxt_carry = st.wrap & ~dir_down;
`endif
        nxt_h = st.h;
        nxt_l = st.l;
      end
      default: ;
    endcase
  end

  // Count and pulse registers; clr forces RST_VAL immediately.
  always_ff @(posedge clk_1 or posedge clr) begin
    if (clr) begin
      cnt_h_q <= RST_H;
      cnt_l_q <= RST_L;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      cnt_h_q <= nxt_h;
      cnt_l_q <= nxt_l;
      carry_q <= nxt_carry;
      err_q   <= nxt_err;
    end
  end

`ifdef BCD_CNT_DOWN_EN
  // Borrow pulse register, present only when down-counting is built.
  always_ff @(posedge clk_1 or posedge clr) begin
    if (clr) borrow_q <= 1'b0;
    else     borrow_q <= nxt_borrow;
  end
  assign bus.borrow = borrow_q;
`else
  assign bus.borrow = 1'b0;
`endif

  assign bus.cnt_H    = cnt_h_q;
  assign bus.cnt_L    = cnt_l_q;
  assign bus.carry    = carry_q;
  assign bus.load_err = err_q;

endmodule

// File: tb/tb_bcd_modcnt.sv
// Self-checking bench for bcd_modcnt: MOD=24, MOD=60 and RST_VAL=12 instances.
module tb_bcd_modcnt;

  logic clk_1 = 1'b0;
  logic clr;
  always #5 clk_1 = ~clk_1;

`ifdef BCD_CNT_DOWN_EN
  localparam bit DOWN_EN = 1'b1;
`else
  localparam bit DOWN_EN = 1'b0;
`endif

  bcd_modcnt_if if24 ();
  bcd_modcnt_if if60 ();
  bcd_modcnt_if if24r ();

  bcd_modcnt #(.MOD(24), .RST_VAL(0))  u24  (.clk_1(clk_1), .clr(clr), .bus(if24.slave));
  bcd_modcnt #(.MOD(60), .RST_VAL(0))  u60  (.clk_1(clk_1), .clr(clr), .bus(if60.slave));
  bcd_modcnt #(.MOD(24), .RST_VAL(12)) u24r (.clk_1(clk_1), .clr(clr), .bus(if24r.slave));

  typedef struct {
    int unsigned sel;
    logic tick, down, set_l, set_h, load;
    logic [3:0] ld_h, ld_l;
    logic [3:0] eh, el;
    logic ec, eb, ee;
  } vec_t;

  vec_t sb_q[$];
  vec_t tbl[$];
  int tests = 0;
  int fails = 0;
  int v60 = 0;

  function automatic vec_t mk(input int unsigned sel, input logic tick, input logic down,
                              input logic sl, input logic sh, input logic ld,
                              input int lh, input int ll, input int eh, input int el,
                              input logic ec, input logic eb, input logic ee);
    vec_t v;
    v.sel = sel; v.tick = tick; v.down = down; v.set_l = sl; v.set_h = sh; v.load = ld;
    v.ld_h = 4'(lh); v.ld_l = 4'(ll); v.eh = 4'(eh); v.el = 4'(el);
    v.ec = ec; v.eb = eb; v.ee = ee;
    return v;
  endfunction

  // Value-based reference model written straight from the command rules.
  function automatic void mdl(input int mod, inout int v, inout vec_t s);
    int h, l, lv;
    h = v / 10; l = v % 10;
    s.ec = 1'b0; s.eb = 1'b0; s.ee = 1'b0;
    lv = int'(s.ld_h) * 10 + int'(s.ld_l);
    if (s.load) begin
      if (s.ld_h <= 9 && s.ld_l <= 9 && lv < mod) v = lv;
      else s.ee = 1'b1;
    end else if (s.set_l) begin
      if (l == 9 || v + 1 >= mod) l = 0; else l = l + 1;
      v = h * 10 + l;
    end else if (s.set_h) begin
      if ((h + 1) * 10 + l >= mod) h = 0; else h = h + 1;
      v = h * 10 + l;
    end else if (s.tick) begin
      if (DOWN_EN && s.down) begin
        if (v == 0) begin v = mod - 1; s.eb = 1'b1; end else v = v - 1;
      end else begin
        if (v == mod - 1) begin v = 0; s.ec = 1'b1; end else v = v + 1;
      end
    end
    s.eh = 4'(v / 10); s.el = 4'(v % 10);
  endfunction

  task automatic drive_in(input vec_t v);
    case (v.sel)
      0: begin if24.tick = v.tick; if24.down = v.down; if24.set_L = v.set_l; if24.set_H = v.set_h;
               if24.load = v.load; if24.load_H = v.ld_h; if24.load_L = v.ld_l; end
      1: begin if60.tick = v.tick; if60.down = v.down; if60.set_L = v.set_l; if60.set_H = v.set_h;
               if60.load = v.load; if60.load_H = v.ld_h; if60.load_L = v.ld_l; end
      default: begin if24r.tick = v.tick; if24r.down = v.down; if24r.set_L = v.set_l; if24r.set_H = v.set_h;
               if24r.load = v.load; if24r.load_H = v.ld_h; if24r.load_L = v.ld_l; end
    endcase
  endtask

  task automatic idle(input int unsigned sel);
    drive_in(mk(sel, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic get_out(input int unsigned sel, output logic [3:0] h, output logic [3:0] l,
                         output logic c, output logic b, output logic e);
    case (sel)
      0:       begin h = if24.cnt_H;  l = if24.cnt_L;  c = if24.carry;  b = if24.borrow;  e = if24.load_err;  end
      1:       begin h = if60.cnt_H;  l = if60.cnt_L;  c = if60.carry;  b = if60.borrow;  e = if60.load_err;  end
      default: begin h = if24r.cnt_H; l = if24r.cnt_L; c = if24r.carry; b = if24r.borrow; e = if24r.load_err; end
    endcase
  endtask

  task automatic check_front(input string tag);
    vec_t e;
    logic [3:0] h, l;
    logic c, b, er;
    tests++;
    if (sb_q.size() == 0) begin
      fails++;
      $display("FAIL %s: no expected entry queued", tag);
      return;
    end
    e = sb_q.pop_front();
    get_out(e.sel, h, l, c, b, er);
    if ({h, l, c, b, er} !== {e.eh, e.el, e.ec, e.eb, e.ee}) begin
      fails++;
      $display("FAIL %s: got H=%0d L=%0d carry=%b borrow=%b load_err=%b, expected H=%0d L=%0d carry=%b borrow=%b load_err=%b",
               tag, h, l, c, b, er, e.eh, e.el, e.ec, e.eb, e.ee);
    end
  endtask

  // Apply one command for one cycle, then compare after the edge.
  task automatic step(input vec_t v, input string tag);
    @(negedge clk_1);
    drive_in(v);
    sb_q.push_back(v);
    @(posedge clk_1);
    #1;
    idle(v.sel);
    check_front(tag);
  endtask

  initial begin
    vec_t v;
    idle(0); idle(1); idle(2);
    clr = 1'b1;
    #3;
    sb_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); check_front("reset_mod24");
    sb_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); check_front("reset_mod60");
    sb_q.push_back(mk(2, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0)); check_front("reset_rst12");
    @(negedge clk_1);
    clr = 1'b0;

    // Directed vectors, modulus 24: sel,tick,down,setL,setH,load,ldH,ldL, expH,expL,carry,borrow,err
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 2, 2,  2, 2, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0,  2, 3, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 2, 3,  2, 3, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0,  2, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 9,  1, 9, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0,  0, 9, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 5,  0, 5, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0,  0, 6, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 2, 5,  0, 6, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 10, 0, 6, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 2, 4,  0, 6, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 15, 0, 0, 6, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 7,  0, 7, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 7, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 2, 3,  2, 3, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0,  0, 3, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 1, 2, 2,  2, 2, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 9,  0, 9, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0,  1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0,  DOWN_EN ? 0 : 1, DOWN_EN ? 9 : 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0,  DOWN_EN ? 2 : 0, DOWN_EN ? 3 : 1, 0, DOWN_EN, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0,  DOWN_EN ? 2 : 0, DOWN_EN ? 2 : 2, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 2, 3,  2, 3, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0));
    for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("mod24_vec%0d", i));

    // Randomised commands on the modulus-60 instance against the reference model.
    for (int i = 0; i < 200; i++) begin
      v = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      v.load  = ($urandom_range(0, 7) == 0);
      v.set_l = ($urandom_range(0, 5) == 0);
      v.set_h = ($urandom_range(0, 5) == 0);
      v.tick  = ($urandom_range(0, 2) != 0);
      v.down  = ($urandom_range(0, 1) == 1);
      v.ld_h  = 4'($urandom_range(0, 10));
      v.ld_l  = 4'($urandom_range(0, 10));
      mdl(60, v60, v);
      step(v, $sformatf("mod60_rand%0d", i));
    end

    // Wrap and load-over-tick corner cases on the modulus-60 instance.
    step(mk(1, 0, 0, 0, 0, 1, 5, 9,  5, 9, 0, 0, 0), "mod60_load59");
    step(mk(1, 1, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0), "mod60_wrap");
    step(mk(1, 1, 0, 0, 0, 1, 3, 0,  3, 0, 0, 0, 0), "mod60_load_over_tick");
    step(mk(1, 0, 0, 0, 0, 1, 5, 9,  5, 9, 0, 0, 0), "mod60_reload59");
    step(mk(1, 1, 0, 0, 0, 1, 5, 9,  5, 9, 0, 0, 0), "mod60_load_blocks_wrap");
    step(mk(1, 0, 0, 1, 0, 0, 0, 0,  5, 0, 0, 0, 0), "mod60_setL_59");
    step(mk(1, 0, 0, 0, 0, 1, 5, 9,  5, 9, 0, 0, 0), "mod60_load59b");
    step(mk(1, 0, 0, 0, 1, 0, 0, 0,  0, 9, 0, 0, 0), "mod60_setH_59");
    step(mk(1, 1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0), "mod60_digit_roll");

    // RST_VAL=12: count, then clr between edges while ticking.
    step(mk(2, 1, 0, 0, 0, 0, 0, 0,  1, 3, 0, 0, 0), "rst12_tick13");
    step(mk(2, 1, 0, 0, 0, 0, 0, 0,  1, 4, 0, 0, 0), "rst12_tick14");
    @(negedge clk_1);
    if24r.tick = 1'b1;
    sb_q.push_back(mk(2, 0, 0, 0, 0, 0, 0, 0,  1, 5, 0, 0, 0));
    @(posedge clk_1);
    #1;
    check_front("rst12_tick15");
    #1;
    clr = 1'b1;
    #1;
    sb_q.push_back(mk(2, 0, 0, 0, 0, 0, 0, 0,  1, 2, 0, 0, 0)); check_front("rst12_async_clr");
    sb_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0)); check_front("mod24_async_clr");
    @(posedge clk_1);
    #1;
    sb_q.push_back(mk(2, 0, 0, 0, 0, 0, 0, 0,  1, 2, 0, 0, 0)); check_front("rst12_clr_held");
    @(negedge clk_1);
    clr = 1'b0;
    sb_q.push_back(mk(2, 0, 0, 0, 0, 0, 0, 0,  1, 3, 0, 0, 0));
    @(posedge clk_1);
    #1;
    idle(2);
    check_front("rst12_first_tick");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bcd_modcnt.md
# bcd_modcnt

Parametrised two-digit BCD modulo counter for the clock datapath, the successor to the fixed hour counter. A single instance, with MOD chosen per use, serves the hour (24), minute/second (60) and 12-hour (12) digit pairs. Features: per-digit manual set with legal-range wrap, parallel load with range checking, single-cycle carry pulses for chaining, and optional down-counting. It sits between the 1 Hz tick generator and the seven-segment display mux.

## Interface
Parameters:
- MOD, default 24: count modulus. Legal range 2..100; the count sequence is 0..MOD-1.
- RST_VAL, default 0: value applied on clr. Must be less than MOD.

Ports:
- clk_1  in  1: system clock. All state updates on the rising edge.
- clr  in  1: reset, asynchronous, active-high.
- tick  in  1: count enable, sampled on clk_1.
- down  in  1: count direction; 1 = decrement. Honoured only with BCD_CNT_DOWN_EN.
- set_L  in  1: increment the low digit (manual set).
- set_H  in  1: increment the high digit (manual set).
- load  in  1: parallel load request.
- load_L  in  4: BCD low digit to load.
- load_H  in  4: BCD high digit to load.
- cnt_L  out  4: BCD low digit, registered.
- cnt_H  out  4: BCD high digit, registered.
- carry  out  1: one-cycle pulse when an up-count wraps from MOD-1 to 0.
- borrow  out  1: one-cycle pulse when a down-count wraps from 0 to MOD-1.
- load_err  out  1: one-cycle pulse when a load is rejected.

## Operation
- Value V = 10*cnt_H + cnt_L. Both digits are always in 0..9 and V is always in 0..MOD-1. No command may produce an illegal state.
- Priority per edge: clr > load > set_L > set_H > tick. Only the highest-priority active command acts.
- load: accepted if load_L ≤ 9, load_H ≤ 9, and 10*load_H + load_L < MOD; the digits are then written. Otherwise the state is held and load_err pulses.
- set_L: L' = L+1. If L = 9 or 10*H + L + 1 ≥ MOD, then L' = 0. H is unchanged.
- set_H: H' = H+1. If 10*(H+1) + L ≥ MOD, then H' = 0. L is unchanged. For example, with MOD = 24, 19 → 09 and 23 → 03.
- tick, up: V' = V+1 in BCD (L = 9 → L = 0, H+1). If V = MOD-1, then V' = 0 and carry pulses.
- tick, down (macro only): V' = V-1 in BCD (L = 0 → L = 9, H-1). If V = 0, then V' = MOD-1 and borrow pulses.
- set_L, set_H and load never pulse carry or borrow.
- carry, borrow and load_err are 0 on every edge where their condition is not met. They are never held.

## Timing
- Reset values: cnt_H/cnt_L = digits of RST_VAL; carry, borrow and load_err = 0. clr takes effect immediately. On deassertion, the first clk_1 edge may act.
- clr asserted mid-operation overrides any command in the same edge. No pulse is emitted.
- Latency 1: a command sampled at edge n is visible on the outputs after edge n.
- carry, borrow and load_err are high for exactly one clk_1 cycle, coincident with the wrapped or held value.
- Back-to-back ticks on consecutive edges are supported. Each edge counts one step.

## Configuration
- BCD_CNT_DOWN_EN defined: the down input selects decrement on tick, and borrow is generated as specified.
- BCD_CNT_DOWN_EN undefined: down is ignored (treated as 0), borrow is tied to 0, and decrement logic is not built.

## Test plan
- MOD=24: clr, load 22, then three ticks → 23, 00 with carry=1 for one cycle, then 01 with carry=0.
- MOD=24, V=23: set_L → 20. Load 19, then set_H → 09. set_L and set_H together at V=05 → 06 (set_L wins).
- MOD=24: load 25 → state held, load_err=1 for one cycle. Load 1A (load_L=10) → rejected the same way. Load 07 → accepted, load_err=0.
- MOD=60: load 59, tick → 00 with carry. Tick with load asserted at the same edge → load wins, no count.
- BCD_CNT_DOWN_EN, MOD=24: V=10, down tick → 09. V=00, down tick → 23 with borrow=1 for one cycle.
- RST_VAL=12, MOD=24: assert clr asynchronously between edges while ticking → outputs 12 immediately. After release, the next tick → 13.
